// File: rtl/tick_gen_prog_pkg.sv
// tick_gen_prog_pkg: shared FSM encoding, mode constants and divisor floor
package tick_gen_prog_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FINISH = 2'd2} state_t;
  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_BURST = 1'b1;
  localparam int MIN_DIV = 2;
endpackage

// File: rtl/tick_div_core.sv
// tick_div_core: period counter with wrap detect and deferred divisor update
// Ports: clk/reset; run_i = FSM in RUN; adv_i = counting this cycle;
// div_wr_i/div_in_i = divisor write; wrap_o = counter at last count of period.
module tick_div_core
  import tick_gen_prog_pkg::*;
#(
  parameter int DIV_W = 20,
  parameter int DEF_DIV = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_i,
  input  logic             adv_i,
  input  logic             div_wr_i,
  input  logic [DIV_W-1:0] div_in_i,
  output logic             wrap_o
);
  logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d, pend_q, pend_d, wr_val;
  logic pend_v_q, pend_v_d;
  always_comb begin
    wr_val = (div_in_i < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : div_in_i;
    wrap_o = adv_i && (cnt_q == div_q - DIV_W'(1));
    cnt_d = (adv_i && !wrap_o) ? cnt_q + DIV_W'(1) : '0;
    pend_d = div_wr_i ? wr_val : pend_q;
    // while running, a write only becomes live at the next wrap; a write on the wrap itself wins
    pend_v_d = run_i && !wrap_o && (div_wr_i || pend_v_q);
    div_d = (!run_i || wrap_o) ? (div_wr_i ? wr_val : pend_v_q ? pend_q : div_q) : div_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      div_q <= DIV_W'(DEF_DIV);
      pend_q <= DIV_W'(DEF_DIV);
      pend_v_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
      pend_q <= pend_d;
      pend_v_q <= pend_v_d;
    end
  end
endmodule

// File: rtl/tick_gen_prog.sv
// tick_gen_prog: programmable periodic / burst tick generator
// Ports: clk, reset (sync, active high); en, mode, start, div_wr, div_in, burst_len in;
// tick (1-clock pulse per period), busy (RUN), done (burst end pulse), tick_cnt out.
module tick_gen_prog
  import tick_gen_prog_pkg::*;
#(
  parameter int DIV_W = 20,
  parameter int DEF_DIV = 1000,
  parameter int EVT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             start,
  input  logic             div_wr,
  input  logic [DIV_W-1:0] div_in,
  input  logic [EVT_W-1:0] burst_len,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic [EVT_W-1:0] tick_cnt
);
  state_t state_q, state_d;
  logic mode_q, mode_d, tick_q, tick_d, enter, run, wrap;
  logic [EVT_W-1:0] len_q, len_d, cnt_q, cnt_d;
  tick_div_core #(.DIV_W(DIV_W), .DEF_DIV(DEF_DIV)) u_core (
    .clk(clk),
    .reset(reset),
    .run_i(run),
    .adv_i(run && en),
    .div_wr_i(div_wr),
    .div_in_i(div_in),
    .wrap_o(wrap)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q <= MODE_PERIODIC;
      len_q <= '0;
      cnt_q <= '0;
      tick_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      tick_q <= tick_d;
    end
  end
  always_comb begin
    run = state_q == RUN;
    enter = state_q == IDLE && en && (mode == MODE_PERIODIC || (start && burst_len != '0));
    // burst completion is seen the cycle after the final tick, so done follows that tick by one clock
    state_d = enter ? RUN : !run ? IDLE : !en ? IDLE :
              (mode_q == MODE_BURST && cnt_q == len_q) ? FINISH : RUN;
    mode_d = enter ? mode : mode_q;
    len_d = enter ? burst_len : len_q;
    cnt_d = enter ? '0 : wrap ? cnt_q + EVT_W'(1) : cnt_q;
    tick_d = wrap;
  end
  always_comb begin
    tick = tick_q;
    busy = state_q == RUN;
    done = state_q == FINISH;
    tick_cnt = cnt_q;
  end
endmodule

// File: doc/tick_gen_prog.md
TICK_GEN_PROG -- requirements
Module: tick_gen_prog

Interface
REQ-001 SHALL have parameter DIV_W, default 20: period counter width.
REQ-002 SHALL have parameter DEF_DIV, default 1000: reset period in clocks (10 us at 100 MHz).
REQ-003 SHALL have parameter EVT_W, default 8: width of burst length and tick count.
REQ-004 SHALL have port clk, input, 1: single system clock, all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port en, input, 1: generator enable; low forces IDLE.
REQ-007 SHALL have port mode, input, 1: 0 = periodic, 1 = burst (one-shot run of N ticks).
REQ-008 SHALL have port start, input, 1: single-cycle request that begins a burst.
REQ-009 SHALL have port div_wr, input, 1: write strobe for div_in.
REQ-010 SHALL have port div_in, input, DIV_W: new period in clocks.
REQ-011 SHALL have port burst_len, input, EVT_W: tick count for a burst.
REQ-012 SHALL have port tick, output, 1: registered one-clock pulse, once per period.
REQ-013 SHALL have port busy, output, 1: high while in RUN.
REQ-014 SHALL have port done, output, 1: one-clock pulse at burst completion.
REQ-015 SHALL have port tick_cnt, output, EVT_W: ticks issued since RUN entry.

Function
REQ-016 SHALL implement the FSM states IDLE, RUN and FINISH.
REQ-017 IDLE->RUN SHALL occur when en=1 and mode=0, or when en=1, mode=1, start=1 and burst_len!=0.
REQ-018 The block SHALL ignore start when burst_len=0, when en=0 or when not in IDLE.
REQ-019 SHALL latch mode and burst_len at RUN entry and ignore later changes until the block returns to IDLE.
REQ-020 On RUN entry, the period counter and tick_cnt SHALL clear to 0.
REQ-021 The counter SHALL count 0..div_reg-1 and wrap.
REQ-022 tick SHALL go high for exactly one clock at each wrap.
REQ-023 The first tick SHALL go high div_reg clocks after the RUN-entry edge, and every div_reg clocks after that.
REQ-024 tick_cnt SHALL increment with each tick and wrap modulo 2^EVT_W in periodic mode.
REQ-025 In burst mode, when tick_cnt reaches the latched burst_len, the block SHALL go to FINISH on that edge.
REQ-026 FINISH SHALL last one clock with done=1, busy=0 and tick=0, then go to IDLE.
REQ-027 tick_cnt SHALL hold its value in IDLE and FINISH.
REQ-028 In RUN, en=0 SHALL move the block to IDLE on the next edge: counter cleared, tick=0, no done (abort).
REQ-029 In IDLE, div_wr SHALL load div_reg on the next edge.
REQ-030 In RUN, div_wr SHALL load a pending register that is copied into div_reg at the next wrap.
REQ-031 If div_wr and a wrap occur in the same cycle, the new value SHALL govern the following period.
REQ-032 div_in values 0 and 1 SHALL be clamped to 2 when written.
REQ-033 Back-to-back div_wr writes SHALL behave as last write wins.
REQ-034 start and div_wr asserted in the same IDLE cycle SHALL enter RUN using the newly written period.

Reset
REQ-035 On reset=1 at a clock edge, all outputs SHALL go to 0: tick, busy, done and tick_cnt.
REQ-036 On reset=1, state SHALL go to IDLE, the counter to 0, div_reg and the pending register to DEF_DIV, and any pending-write flag SHALL clear.
REQ-037 Reset SHALL override every other input, including mid-burst, and SHALL produce no done pulse.

Structure
REQ-038 A shared package SHALL hold the state encoding (IDLE, RUN, FINISH), the mode constants (MODE_PERIODIC=0, MODE_BURST=1) and the minimum-divisor constant 2.
REQ-039 The period counter with its wrap detect and pending-divisor logic SHALL be one sub-module, tick_div_core.
REQ-040 The FSM, tick_cnt and the output registers SHALL stay in tick_gen_prog.

Verification
REQ-041 Scenario: defaults, en=1, mode=0 for 3500 clocks -> ticks at clocks 1000, 2000 and 3000 after RUN entry, each 1 clock wide, tick_cnt=3.
REQ-042 Scenario: div_in=4 written in IDLE, then mode=1, burst_len=3, start pulse -> ticks at +4, +8 and +12, done one clock after the third tick's edge, busy low afterwards.
REQ-043 Scenario: period 10 running, div_wr with div_in=6 at clock 3 of a period -> that period stays 10, following periods are 6.
REQ-044 Scenario: burst of 5 at period 4, en dropped after the 2nd tick -> IDLE next edge, no further ticks, done never asserts, tick_cnt holds 2.
REQ-045 Scenario: div_in=0 written, then periodic run -> period 2 (tick every 2nd clock); start with burst_len=0 -> ignored, busy stays 0.
REQ-046 Scenario: reset asserted mid-burst -> next edge all outputs 0, div_reg=DEF_DIV, no done; a following periodic run ticks every 1000 clocks.
